rsb_ret_ctrl: RTL and testbench
===============================

// Module: rsb_ret_ctrl
// PURPOSE
//  Client-side controller for the 32-entry return stack buffer.
//  - Decodes CALL/RET from the decode stage and drives RSB push/pop.
//  - Captures the RSB top as the predicted RET target and tracks in-flight RET predictions in a FIFO.
//  - Checks each prediction against the resolved target from execute and flags mispredictions.
//  - Sits between decode/execute and the RSB.
// PARAMETERS
//  PEND_DEPTH  8   in-flight RET predictions tracked (power of 2, >=2)
//  CNT_W       32  width of statistics counters
// PORTS
//  clk               in   1      clock
//  rst_n             in   1      reset, asynchronous, active-low
//  dec_valid_i       in   1      decode slot valid
//  dec_ready_o       out  1      controller can accept decode slot
//  dec_is_call_i     in   1      slot is a CALL
//  dec_is_ret_i      in   1      slot is a RET
//  dec_pc_i          in   64     PC of slot
//  dec_len_i         in   4      instruction length in bytes
//  rsb_push_o        out  1      push to RSB (combinational)
//  rsb_push_addr_o   out  64     return address = dec_pc_i + dec_len_i
//  rsb_pop_o         out  1      pop from RSB (combinational)
//  rsb_top_i         in   64     RSB top entry, 0 when RSB empty
//  rsb_underflow_i   in   1      RSB pop while empty
//  pred_valid_o      out  1      registered RET prediction valid
//  pred_target_o     out  64     predicted RET target
//  res_valid_i       in   1      execute resolved oldest RET
//  res_target_i      in   64     actual RET target
//  mispred_o         out  1      one-cycle mispredict pulse
//  mispred_target_o  out  64     redirect target on mispredict
//  spurious_o        out  1      one-cycle pulse: resolve with FIFO empty
//  flush_i           in   1      pipeline flush
//  ret_cnt_o         out  CNT_W  RETs resolved
//  mispred_cnt_o     out  CNT_W  mispredicts
// BEHAVIOUR
//  Reset:
//  - All outputs 0; FIFO empty; counters 0. dec_ready_o = 1 after reset.
//  Handshake:
//  - accept = dec_valid_i & dec_ready_o.
//  - dec_ready_o = !flush_i & (fifo_cnt < PEND_DEPTH). Same-cycle dequeue is not credited.
//  RSB drive (combinational, gated by accept):
//  - CALL: rsb_push_o = 1. rsb_push_addr_o = dec_pc_i + zero-extended dec_len_i, mod 2^64.
//  - RET: rsb_pop_o = 1.
//  - CALL and RET both set: CALL wins, no pop.
//  - flush_i = 1: push and pop are forced to 0.
//  RET accept:
//  - Enqueue {target = rsb_top_i, hit = !rsb_underflow_i}.
//  - Next cycle: pred_valid_o = 1, pred_target_o = rsb_top_i.
//  - pred_valid_o is otherwise 0. On underflow, pred_target_o = 0 and hit = 0.
//  Resolve (res_valid_i, FIFO non-empty): dequeue head.
//  - Mispredict when !hit or head.target != res_target_i.
//  - On mispredict, next cycle: mispred_o = 1, mispred_target_o = res_target_i. Also clear the whole FIFO, since younger RETs are stale.
//  - ret_cnt_o +1 on every resolve. mispred_cnt_o +1 on every mispredict.
//  - Both counters saturate at all-ones.
//  res_valid_i with FIFO empty:
//  - No dequeue, no count. spurious_o = 1 next cycle.
//  Simultaneous events:
//  - RET accept + resolve (no mispredict): fifo_cnt unchanged, head advances.
//  - Resolve mispredict + RET accept in the same cycle: the new entry is also discarded.
//  - flush_i: FIFO cleared next edge. A resolve in the same cycle is ignored (no counts, no pulses).
//  Wrap:
//  - FIFO read/write pointers are log2(PEND_DEPTH) bits and wrap modulo PEND_DEPTH.
//  - fifo_cnt is log2(PEND_DEPTH)+1 bits.
//  Reset mid-operation:
//  - Asynchronous clear of FIFO, pulses and counters.
//  - The RSB is reset by its own rst_n.
// TESTING
//  1. CALL pc=0x1000 len=4 -> rsb_push_o=1, addr 0x1004. RET with rsb_top_i=0x1004 -> pred_target_o=0x1004 next cycle.
//  2. Resolve 0x1004 -> mispred_o=0, ret_cnt_o=1. Then RET pred 0x2000, resolve 0x3000 -> mispred_o=1, target 0x3000, mispred_cnt_o=1.
//  3. 8 RETs unresolved -> dec_ready_o=0, no pop on 9th. One resolve -> dec_ready_o=1 next cycle.
//  4. RET with rsb_underflow_i=1 -> pred_target_o=0. Resolve 0x40 -> mispred_o=1.
//  5. 3 pending, mispredict on head with RET accepted same cycle -> FIFO empty. Next res_valid_i -> spurious_o=1.
//  6. flush_i with dec_valid_i CALL -> no push, dec_ready_o=0, FIFO empty. rst_n low mid-stream -> all outputs 0.

Source files
------------

// File: rtl/rsb_ret_ctrl.sv
// Return stack buffer client controller: drives RSB push/pop from decode and
// tracks in-flight RET predictions for checking against execute resolution.
module rsb_ret_ctrl #(
  parameter int unsigned PEND_DEPTH = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  input  logic             dec_is_call_i,
  input  logic             dec_is_ret_i,
  input  logic [63:0]      dec_pc_i,
  input  logic [3:0]       dec_len_i,
  output logic             rsb_push_o,
  output logic [63:0]      rsb_push_addr_o,
  output logic             rsb_pop_o,
  input  logic [63:0]      rsb_top_i,
  input  logic             rsb_underflow_i,
  output logic             pred_valid_o,
  output logic [63:0]      pred_target_o,
  input  logic             res_valid_i,
  input  logic [63:0]      res_target_i,
  output logic             mispred_o,
  output logic [63:0]      mispred_target_o,
  output logic             spurious_o,
  input  logic             flush_i,
  output logic [CNT_W-1:0] ret_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int unsigned PTR_W = $clog2(PEND_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(PEND_DEPTH);

  logic [63:0]           tgt_q [PEND_DEPTH];
  logic [PEND_DEPTH-1:0] hit_q;
  logic [PTR_W-1:0]      wp, rp;
  logic [PTR_W:0]        cnt;

  logic        accept, call_acc, ret_acc;
  logic        fifo_empty, res_do, res_spur, mis;
  logic [63:0] enq_tgt;

  always_comb begin
    dec_ready_o     = !flush_i && (cnt < DEPTH_C);
    accept          = dec_valid_i && dec_ready_o;
    call_acc        = accept && dec_is_call_i;
    // CALL takes priority when both flags are set on one slot
    ret_acc         = accept && dec_is_ret_i && !dec_is_call_i;
    rsb_push_o      = call_acc;
    rsb_pop_o       = ret_acc;
    rsb_push_addr_o = dec_pc_i + {60'd0, dec_len_i};
    enq_tgt         = rsb_underflow_i ? '0 : rsb_top_i;
    fifo_empty      = (cnt == '0);
    res_do          = res_valid_i && !flush_i && !fifo_empty;
    res_spur        = res_valid_i && !flush_i && fifo_empty;
    mis             = res_do && (!hit_q[rp] || (tgt_q[rp] != res_target_i));
  end

  always_ff @(posedge clk) begin
    if (ret_acc) tgt_q[wp] <= enq_tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp               <= '0;
      rp               <= '0;
      cnt              <= '0;
      hit_q            <= '0;
      pred_valid_o     <= 1'b0;
      pred_target_o    <= '0;
      mispred_o        <= 1'b0;
      mispred_target_o <= '0;
      spurious_o       <= 1'b0;
      ret_cnt_o        <= '0;
      mispred_cnt_o    <= '0;
    end else begin
      pred_valid_o <= ret_acc;
      mispred_o    <= mis;
      spurious_o   <= res_spur;
      if (ret_acc) begin
        pred_target_o <= enq_tgt;
        hit_q[wp]     <= !rsb_underflow_i;
      end
      if (mis) mispred_target_o <= res_target_i;
      if (res_do && (ret_cnt_o != '1)) ret_cnt_o <= ret_cnt_o + CNT_W'(1);
      if (mis && (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);

      // a mispredict makes every younger entry stale, including one enqueued this cycle
      if (flush_i || mis) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (ret_acc) wp <= wp + PTR_W'(1);
        if (res_do)  rp <= rp + PTR_W'(1);
        unique case ({ret_acc, res_do})
          2'b10:   cnt <= cnt + (PTR_W+1)'(1);
          2'b01:   cnt <= cnt - (PTR_W+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsb_ret_ctrl.sv
// Directed bench for rsb_ret_ctrl; expected pulse events are queued at issue
// time and matched by an independent negedge monitor.
module tb_rsb_ret_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid_i, dec_ready_o, dec_is_call_i, dec_is_ret_i;
  logic [63:0] dec_pc_i;
  logic [3:0]  dec_len_i;
  logic        rsb_push_o, rsb_pop_o;
  logic [63:0] rsb_push_addr_o, rsb_top_i;
  logic        rsb_underflow_i;
  logic        pred_valid_o;
  logic [63:0] pred_target_o;
  logic        res_valid_i;
  logic [63:0] res_target_i;
  logic        mispred_o;
  logic [63:0] mispred_target_o;
  logic        spurious_o, flush_i;
  logic [31:0] ret_cnt_o, mispred_cnt_o;

  int checks = 0;
  int failures = 0;

  logic [63:0] pred_q[$];
  logic [63:0] mis_q[$];
  logic        spur_q[$];

  rsb_ret_ctrl #(.PEND_DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_is_call_i(dec_is_call_i), .dec_is_ret_i(dec_is_ret_i),
    .dec_pc_i(dec_pc_i), .dec_len_i(dec_len_i),
    .rsb_push_o(rsb_push_o), .rsb_push_addr_o(rsb_push_addr_o), .rsb_pop_o(rsb_pop_o),
    .rsb_top_i(rsb_top_i), .rsb_underflow_i(rsb_underflow_i),
    .pred_valid_o(pred_valid_o), .pred_target_o(pred_target_o),
    .res_valid_i(res_valid_i), .res_target_i(res_target_i),
    .mispred_o(mispred_o), .mispred_target_o(mispred_target_o),
    .spurious_o(spurious_o), .flush_i(flush_i),
    .ret_cnt_o(ret_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pred_valid_o) begin
        if (pred_q.size() == 0) check("pred_unexpected", 64'd1, 64'd0);
        else check("pred_target", pred_target_o, pred_q.pop_front());
      end
      if (mispred_o) begin
        if (mis_q.size() == 0) check("mispred_unexpected", 64'd1, 64'd0);
        else check("mispred_target", mispred_target_o, mis_q.pop_front());
      end
      if (spurious_o) begin
        if (spur_q.size() == 0) check("spurious_unexpected", 64'd1, 64'd0);
        else check("spurious", 64'(spurious_o), 64'(spur_q.pop_front()));
      end
    end
  end

  task automatic drive(input logic v, input logic c, input logic r, input logic [63:0] pc,
                       input logic [3:0] len, input logic [63:0] top, input logic uf,
                       input logic rv, input logic [63:0] rt, input logic fl);
    dec_valid_i = v; dec_is_call_i = c; dec_is_ret_i = r; dec_pc_i = pc; dec_len_i = len;
    rsb_top_i = top; rsb_underflow_i = uf; res_valid_i = rv; res_target_i = rt; flush_i = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 64'd0, 4'd0, 64'd0, 0, 0, 64'd0, 0);
  endtask

  task automatic ret_op(input logic [63:0] top);
    drive(1, 0, 1, 64'h0, 4'd0, top, 0, 0, 64'd0, 0);
  endtask

  task automatic resolve(input logic [63:0] t);
    drive(0, 0, 0, 64'h0, 4'd0, 64'd0, 0, 1, t, 0);
  endtask

  task automatic check_cnts(input string tag, input logic [31:0] rc, input logic [31:0] mc);
    check({tag, "_ret_cnt"}, 64'(ret_cnt_o), 64'(rc));
    check({tag, "_mispred_cnt"}, 64'(mispred_cnt_o), 64'(mc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    tick(); tick();
    check("rst_pred_valid", 64'(pred_valid_o), 64'd0);
    check("rst_mispred", 64'(mispred_o), 64'd0);
    check("rst_spurious", 64'(spurious_o), 64'd0);
    check("rst_ready", 64'(dec_ready_o), 64'd1);
    check_cnts("rst", 0, 0);
    rst_n = 1'b1;
    tick();

    // CALL then RET returning to its address
    drive(1, 1, 0, 64'h1000, 4'd4, 64'd0, 0, 0, 64'd0, 0);
    check("call_push", 64'(rsb_push_o), 64'd1);
    check("call_addr", rsb_push_addr_o, 64'h1004);
    check("call_pop", 64'(rsb_pop_o), 64'd0);
    tick();
    ret_op(64'h1004);
    check("ret_pop", 64'(rsb_pop_o), 64'd1);
    check("ret_push", 64'(rsb_push_o), 64'd0);
    pred_q.push_back(64'h1004);
    tick();

    resolve(64'h1004);
    tick();
    check_cnts("t2a", 1, 0);
    ret_op(64'h2000);
    pred_q.push_back(64'h2000);
    tick();
    resolve(64'h3000);
    mis_q.push_back(64'h3000);
    tick();
    check_cnts("t2b", 2, 1);

    // CALL+RET on one slot, with address wrap past 2^64
    drive(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 4'hF, 64'd0, 0, 0, 64'd0, 0);
    check("both_push", 64'(rsb_push_o), 64'd1);
    check("both_pop", 64'(rsb_pop_o), 64'd0);
    check("both_addr", rsb_push_addr_o, 64'hD);
    tick();

    // fill the FIFO
    for (int i = 0; i < 8; i++) begin
      ret_op(64'h5000 + 64'(i) * 64'h10);
      check("fill_pop", 64'(rsb_pop_o), 64'd1);
      pred_q.push_back(64'h5000 + 64'(i) * 64'h10);
      tick();
    end
    ret_op(64'h9999);
    check("full_ready", 64'(dec_ready_o), 64'd0);
    check("full_pop", 64'(rsb_pop_o), 64'd0);
    tick();
    resolve(64'h5000);
    check("deq_not_credited", 64'(dec_ready_o), 64'd0);
    tick();
    idle();
    check("ready_after_deq", 64'(dec_ready_o), 64'd1);
    ret_op(64'h5080);
    check("wrap_pop", 64'(rsb_pop_o), 64'd1);
    pred_q.push_back(64'h5080);
    tick();
    for (int i = 1; i <= 8; i++) begin
      resolve(64'h5000 + 64'(i) * 64'h10);
      tick();
    end
    idle();
    check_cnts("t3", 11, 1);
    check("t3_ready", 64'(dec_ready_o), 64'd1);

    // underflowed RET always mispredicts
    drive(1, 0, 1, 64'h0, 4'd0, 64'd0, 1, 0, 64'd0, 0);
    check("uf_pop", 64'(rsb_pop_o), 64'd1);
    pred_q.push_back(64'd0);
    tick();
    resolve(64'h40);
    mis_q.push_back(64'h40);
    tick();
    check_cnts("t4", 12, 2);

    // mispredict on head with a RET accepted in the same cycle
    for (int i = 0; i < 3; i++) begin
      ret_op(64'hA00 + 64'(i) * 64'h10);
      pred_q.push_back(64'hA00 + 64'(i) * 64'h10);
      tick();
    end
    drive(1, 0, 1, 64'h0, 4'd0, 64'hA30, 0, 1, 64'hBAD, 0);
    pred_q.push_back(64'hA30);
    mis_q.push_back(64'hBAD);
    tick();
    check_cnts("t5a", 13, 3);
    resolve(64'h1);
    spur_q.push_back(1'b1);
    tick();
    check_cnts("t5b", 13, 3);

    // flush with a CALL and a resolve pending
    for (int i = 0; i < 2; i++) begin
      ret_op(64'hC00 + 64'(i) * 64'h10);
      pred_q.push_back(64'hC00 + 64'(i) * 64'h10);
      tick();
    end
    drive(1, 1, 0, 64'h7000, 4'd2, 64'd0, 0, 1, 64'hDEAD, 1);
    check("flush_push", 64'(rsb_push_o), 64'd0);
    check("flush_pop", 64'(rsb_pop_o), 64'd0);
    check("flush_ready", 64'(dec_ready_o), 64'd0);
    tick();
    idle();
    check_cnts("t6a", 13, 3);
    check("post_flush_ready", 64'(dec_ready_o), 64'd1);
    resolve(64'h1);
    spur_q.push_back(1'b1);
    tick();
    check_cnts("t6b", 13, 3);

    // asynchronous reset while a prediction is being presented
    ret_op(64'hE00);
    tick();
    idle();
    check("pre_rst_pred_valid", 64'(pred_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_pred_valid", 64'(pred_valid_o), 64'd0);
    check("midrst_pred_target", pred_target_o, 64'd0);
    check("midrst_mispred_target", mispred_target_o, 64'd0);
    check("midrst_push", 64'(rsb_push_o), 64'd0);
    check_cnts("midrst", 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    resolve(64'h1);
    spur_q.push_back(1'b1);
    tick();
    idle();
    tick();
    check_cnts("post_rst", 0, 0);

    check("pred_q_drained", 64'(pred_q.size()), 64'd0);
    check("mis_q_drained", 64'(mis_q.size()), 64'd0);
    check("spur_q_drained", 64'(spur_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
